trace_capture_buffer: RTL

- Synthesizable on-chip trace recorder for the pipelined RISC-V core.
- Snoops the register-bank write port (writeback stage) and records each retired register write with PC and a cycle stamp into a circular buffer.
- Host logic or a bench reads the buffer back through an indexed read port.
- Supports three capture modes: continuous, stop-when-full, and PC-triggered with pre/post history.

---
 rtl/trace_capture_buffer_if.sv | 36 +++
 rtl/trace_capture_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer_if.sv
// rtl/trace_capture_buffer_if.sv - writeback snoop and indexed readout bundle for the trace buffer
interface trace_capture_buffer_if #(
    parameter int DEPTH          = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STAMP_WIDTH    = 16,
    parameter int IDX_WIDTH      = $clog2(DEPTH)
) ();

    // Writeback-stage snoop: one retiring register write per cycle
    logic                      wb_valid;
    logic [REG_ADDR_WIDTH-1:0] wb_dest;
    logic [DATA_WIDTH-1:0]     wb_value;
    logic [DATA_WIDTH-1:0]     wb_pc;

    // Indexed readout: index in, registered entry out one cycle later
    logic [IDX_WIDTH-1:0]      rd_index;
    logic                      rd_valid;
    logic [REG_ADDR_WIDTH-1:0] rd_dest;
    logic [DATA_WIDTH-1:0]     rd_value;
    logic [DATA_WIDTH-1:0]     rd_pc;
    logic [STAMP_WIDTH-1:0]    rd_stamp;

    // Core/host side: drives the snoop and the read index
    modport master (
        output wb_valid, wb_dest, wb_value, wb_pc, rd_index,
        input  rd_valid, rd_dest, rd_value, rd_pc, rd_stamp
    );

    // Recorder side
    modport slave (
        input  wb_valid, wb_dest, wb_value, wb_pc, rd_index,
        output rd_valid, rd_dest, rd_value, rd_pc, rd_stamp
    );

endinterface

// File: rtl/trace_capture_buffer.sv
// rtl/trace_capture_buffer.sv - circular trace recorder of retired register writes with PC and cycle stamp
module trace_capture_buffer #(
    parameter int DEPTH          = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STAMP_WIDTH    = 16,
    parameter int POST_TRIGGER   = 4,
    parameter int IDX_WIDTH      = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  arm,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] trig_pc,
    trace_capture_buffer_if.slave bus,
    output logic [IDX_WIDTH:0]    count,
    output logic [1:0]            state,
    output logic                  triggered,
    output logic                  overflow
);

    localparam int ENTRY_W = REG_ADDR_WIDTH + 2 * DATA_WIDTH + STAMP_WIDTH;
    localparam logic [IDX_WIDTH:0] DEPTH_CNT    = (IDX_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_WIDTH:0] POST_RELOAD  = (IDX_WIDTH + 1)'(POST_TRIGGER - 1);
    localparam logic [IDX_WIDTH:0] CNT_ONE      = (IDX_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAPTURE   = 2'd1,
        ST_WAIT_TRIG = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t                  cur_state;
    state_t                  next_state;

    logic [1:0]              mode_q;
    logic [DATA_WIDTH-1:0]   trig_pc_q;
    logic [IDX_WIDTH-1:0]    wr_ptr;
    logic [STAMP_WIDTH-1:0]  stamp;
    logic [IDX_WIDTH:0]      post_cnt;

    logic [ENTRY_W-1:0]      mem [DEPTH];

    logic                    capturing;
    logic                    wr_event;
    logic                    trig_hit;
    logic                    full;
    logic [IDX_WIDTH-1:0]    rd_phys;
    logic [ENTRY_W-1:0]      rd_entry;

    // Capture qualifiers; arm suppresses any write arriving in its own cycle
    always_comb begin
        full     = (count == DEPTH_CNT);
        wr_event = enable && !arm && capturing && bus.wb_valid;
        trig_hit = wr_event && (cur_state == ST_WAIT_TRIG) && (bus.wb_pc == trig_pc_q);
        rd_phys  = full ? (wr_ptr + bus.rd_index) : bus.rd_index;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic: arm restarts from any state, otherwise only enabled writes move the FSM
    always_comb begin
        next_state = cur_state;
        if (arm) begin
            next_state = (mode == 2'd2) ? ST_WAIT_TRIG : ST_CAPTURE;
        end else if (enable) begin
            case (cur_state)
                ST_CAPTURE: begin
                    if (wr_event) begin
                        if (mode_q == 2'd1 && count == DEPTH_CNT - CNT_ONE) begin
                            next_state = ST_DONE;
                        end else if (mode_q == 2'd2 && post_cnt == CNT_ONE) begin
                            next_state = ST_DONE;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig_hit) begin
                        next_state = (POST_TRIGGER == 1) ? ST_DONE : ST_CAPTURE;
                    end
                end
                default: next_state = cur_state;
            endcase
        end
    end

    // FSM outputs: encoded state and whether the recorder is accepting writes
    always_comb begin
        state     = cur_state;
        capturing = (cur_state == ST_CAPTURE) || (cur_state == ST_WAIT_TRIG);
    end

    // Pointer, count, stamp, trigger and overflow bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q    <= 2'd0;
            trig_pc_q <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            stamp     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else if (arm) begin
            mode_q    <= mode;
            trig_pc_q <= trig_pc;
            wr_ptr    <= '0;
            count     <= '0;
            stamp     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else if (enable) begin
            if (capturing && stamp != '1) begin
                stamp <= stamp + 1'b1;
            end
            if (wr_event) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_ONE;
                end
            end
            if (trig_hit) begin
                triggered <= 1'b1;
                post_cnt  <= POST_RELOAD;
            end else if (wr_event && cur_state == ST_CAPTURE && mode_q == 2'd2) begin
                post_cnt <= post_cnt - CNT_ONE;
            end
        end
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clock) begin
        if (!reset && wr_event) begin
            mem[wr_ptr] <= {bus.wb_dest, bus.wb_value, bus.wb_pc, stamp};
        end
    end

    assign rd_entry = mem[rd_phys];

    // Registered readout from pre-edge pointer, count and contents
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.rd_valid <= 1'b0;
            bus.rd_dest  <= '0;
            bus.rd_value <= '0;
            bus.rd_pc    <= '0;
            bus.rd_stamp <= '0;
        end else if (enable) begin
            bus.rd_valid <= ({1'b0, bus.rd_index} < count);
            bus.rd_dest  <= rd_entry[ENTRY_W-1 -: REG_ADDR_WIDTH];
            bus.rd_value <= rd_entry[2*DATA_WIDTH+STAMP_WIDTH-1 -: DATA_WIDTH];
            bus.rd_pc    <= rd_entry[DATA_WIDTH+STAMP_WIDTH-1 -: DATA_WIDTH];
            bus.rd_stamp <= rd_entry[STAMP_WIDTH-1:0];
        end
    end

endmodule
